uart_tx: RTL and testbench

UART transmitter that serializes bytes from the Trivium datapath (keystream or ciphertext) onto `serial_out`, 8N1, LSB first. It is the transmit half of the chip's serial link; the receive half deserializes `serial_in`. Each byte is accepted through a valid/ready handshake into a one-entry holding register. Frames can therefore be sent back-to-back with no idle gap on the line.

---
 rtl/trivium_pkg.sv | 13 +
 rtl/uart_baud_gen.sv | 35 +++
 rtl/uart_tx.sv | 114 +++++++++++
 tb/tb_uart_tx.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// rtl/trivium_pkg.sv - shared types and constants for the Trivium serial link
package trivium_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 10416;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter pulsing bit_done on the last cycle of each bit
module uart_baud_gen
  import trivium_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a one-entry holding register for gapless frames
module uart_tx
  import trivium_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       tx_busy
);

  uart_tx_state_t state_q, state_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       hold_full_q, hold_full_d;
  logic       serial_q, serial_d;
  logic       bit_done, baud_clear, handshake, load;

  assign tx_ready   = rst_n && ena && !hold_full_q;
  assign handshake  = tx_valid && tx_ready;
  assign serial_out = serial_q;
  assign tx_busy    = (state_q != IDLE) || hold_full_q;

  // Leaving any non-idle state happens on bit_done, where the counter wraps to 0
  // by itself, so holding it clear in IDLE covers every state entry.
  assign baud_clear = (state_q == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (baud_clear),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    load        = 1'b0;
    serial_d    = 1'b1;

    case (state_q)
      IDLE: begin
        if (hold_full_q && ena) load = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // A chained byte goes out even with ena low; only IDLE waits for ena.
        if (bit_done) begin
          if (hold_full_q) load = 1'b1;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d     = hold_data_q;
      state_d     = START;
      hold_full_d = 1'b0;
    end
    if (handshake) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
    end

    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_data_q <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      bit_idx_q   <= 3'd0;
      serial_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      serial_q    <= serial_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, serial_out, tx_busy;

  logic       d_rst_n = 1'b1;
  logic       d_ena = 1'b1;
  logic       d_valid = 1'b0;
  logic [7:0] d_data = 8'h00;
  logic       d_ready, d_serial, d_busy;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .serial_out(serial_out), .tx_busy(tx_busy)
  );

  uart_tx dut_def (
    .clk(clk), .rst_n(d_rst_n), .ena(d_ena), .tx_data(d_data), .tx_valid(d_valid),
    .tx_ready(d_ready), .serial_out(d_serial), .tx_busy(d_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the line is a queue of per-cycle levels; a byte becomes
  // 10*C levels once it leaves the holding slot.
  logic [7:0] m_hold = 8'h00;
  logic [9:0] m_frame;
  bit         m_hold_full = 0, m_active = 0, m_out = 1, m_hs;
  bit         m_q[$];
  bit         model_chk = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold_full = 0;
      m_active    = 0;
      m_out       = 1;
      m_q.delete();
    end else begin
      m_hs = tx_valid && ena && !m_hold_full;
      if (m_q.size() == 0 && m_hold_full && (ena || m_active)) begin
        m_frame = {1'b1, m_hold, 1'b0};
        for (int i = 0; i < 10; i++)
          for (int r = 0; r < C; r++) m_q.push_back(m_frame[i]);
        m_hold_full = 0;
      end
      if (m_q.size() > 0) begin
        m_out    = m_q.pop_front();
        m_active = 1;
      end else begin
        m_out    = 1;
        m_active = 0;
      end
      if (m_hs) begin
        m_hold_full = 1;
        m_hold      = tx_data;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && model_chk) begin
      chk("model_serial", serial_out, m_out);
      chk("model_busy", tx_busy, m_active || m_hold_full);
      chk("model_ready", tx_ready, ena && !m_hold_full);
    end
  end

  // Inputs only change just after posedge, so the negedge value is what the next edge sees.
  int hs_cnt = 0;
  always @(negedge clk) if (rst_n && tx_valid && tx_ready) hs_cnt++;

  bit log_en = 0;
  bit line_log[$];
  always @(negedge clk) if (log_en) line_log.push_back(serial_out);

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] d, input bit keep);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("offer_accepted_in_time", n < 200, 1);
    @(posedge clk);
    #1;
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (tx_busy && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, n < bound, 1);
  endtask

  task automatic check_stream(input string name, input logic [7:0] bq[$]);
    bit         exp[$];
    logic [9:0] f;
    int         i = 0;
    int         bad = 0;
    foreach (bq[k]) begin
      f = {1'b1, bq[k], 1'b0};
      for (int b = 0; b < 10; b++)
        for (int r = 0; r < C; r++) exp.push_back(f[b]);
    end
    while (i < line_log.size() && line_log[i] == 1'b1) i++;
    for (int k = 0; k < exp.size(); k++)
      if (i + k >= line_log.size() || line_log[i+k] !== exp[k]) bad++;
    for (int k = i + exp.size(); k < line_log.size(); k++)
      if (line_log[k] !== 1'b1) bad++;
    chk(name, bad, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;

  vec_t       tbl[5];
  logic [9:0] got;
  logic [7:0] sq[$];
  int         hs0, n;
  time        t0, t1, t2;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // line[i] is the level of the i-th bit period in time order
    tbl[0] = '{8'hA5, 10'b1101001010};
    tbl[1] = '{8'h00, 10'b1000000000};
    tbl[2] = '{8'hFF, 10'b1111111110};
    tbl[3] = '{8'h3C, 10'b1001111000};
    tbl[4] = '{8'h01, 10'b1000000010};

    #2;
    rst_n   = 1'b0;
    d_rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_serial", serial_out, 1);
      chk("rst_ready", tx_ready, 0);
      chk("rst_busy", tx_busy, 0);
    end
    rst_n   = 1'b1;
    d_rst_n = 1'b1;
    step(1);
    chk("ready_after_reset", tx_ready, 1);
    model_chk = 1;

    for (int v = 0; v < 5; v++) begin
      offer(tbl[v].data, 0);
      @(negedge clk); chk("lat_no_fall_at_T", serial_out, 1);
      @(negedge clk); chk("lat_fall_at_T1", serial_out, 0);
      @(negedge clk); got[0] = serial_out;
      for (int i = 1; i < 10; i++) begin
        repeat (C) @(negedge clk);
        got[i] = serial_out;
      end
      chk("frame_bits", got, tbl[v].line);
      repeat (2) @(negedge clk); chk("busy_last_cycle", tx_busy, 1);
      @(negedge clk); chk("busy_after_frame", tx_busy, 0);
      step(1);
    end

    // back-to-back with second byte offered mid-frame
    line_log.delete(); log_en = 1;
    offer(8'h3C, 0);
    chk("hold_full_ready_low", tx_ready, 0);
    step(1);
    chk("ready_after_load", tx_ready, 1);
    offer(8'h7F, 0);
    chk("b2b_ready_low", tx_ready, 0);
    wait_idle("b2b_idle_timeout", 300);
    log_en = 0;
    sq.delete(); sq.push_back(8'h3C); sq.push_back(8'h7F);
    check_stream("b2b_stream", sq);

    // backpressure: tx_valid held high across three bytes
    hs0 = hs_cnt; line_log.delete(); log_en = 1;
    offer(8'hC1, 1);
    offer(8'h99, 1);
    offer(8'h42, 0);
    wait_idle("bp_idle_timeout", 400);
    log_en = 0;
    chk("bp_handshakes", hs_cnt - hs0, 3);
    sq.delete(); sq.push_back(8'hC1); sq.push_back(8'h99); sq.push_back(8'h42);
    check_stream("bp_stream", sq);

    // ena low with an empty slot drops ready combinationally
    ena = 1'b0; #1;
    chk("ena_ready_drop_empty", tx_ready, 0);
    ena = 1'b1; #1;
    chk("ena_ready_restore", tx_ready, 1);
    step(1);

    // ena dropped mid-frame with a chained byte held
    line_log.delete(); log_en = 1;
    offer(8'hE7, 0);
    offer(8'hB8, 0);
    step(3);
    ena = 1'b0; #1;
    chk("ena_ready_drop", tx_ready, 0);
    tx_data = 8'h5D; tx_valid = 1'b1;
    hs0 = hs_cnt;
    wait_idle("ena_idle_timeout", 300);
    log_en = 0;
    sq.delete(); sq.push_back(8'hE7); sq.push_back(8'hB8);
    check_stream("ena_chain_stream", sq);
    step(10);
    chk("ena_low_no_accept", hs_cnt - hs0, 0);
    chk("ena_low_line_idle", serial_out, 1);
    line_log.delete(); log_en = 1;
    ena = 1'b1; #1;
    chk("ena_high_ready", tx_ready, 1);
    step(1);
    tx_valid = 1'b0;
    chk("ena_high_accept", hs_cnt - hs0, 1);
    wait_idle("ena_5d_timeout", 200);
    log_en = 0;
    sq.delete(); sq.push_back(8'h5D);
    check_stream("ena_5d_stream", sq);

    // byte held in IDLE waits for ena
    line_log.delete(); log_en = 1;
    offer(8'h96, 0);
    ena = 1'b0;
    step(8);
    chk("held_idle_line", serial_out, 1);
    chk("held_idle_busy", tx_busy, 1);
    ena = 1'b1;
    wait_idle("held_idle_timeout", 200);
    log_en = 0;
    sq.delete(); sq.push_back(8'h96);
    check_stream("held_idle_stream", sq);

    // async reset at cycle 13 of a frame with a byte held
    offer(8'hF0, 0);
    offer(8'h33, 0);
    repeat (11) @(posedge clk);
    #2;
    chk("pre_reset_line_low", serial_out, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_serial", serial_out, 1);
    chk("async_rst_busy", tx_busy, 0);
    chk("async_rst_ready", tx_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    line_log.delete(); log_en = 1;
    step(60);
    log_en = 0;
    chk("post_rst_busy", tx_busy, 0);
    sq.delete();
    check_stream("post_rst_no_residual", sq);

    // randomized traffic against the model
    for (int cyc = 0; cyc < 2500; cyc++) begin
      tx_valid = ($urandom_range(0, 2) == 0);
      tx_data  = 8'($urandom);
      if ($urandom_range(0, 39) == 0) ena = ~ena;
      step(1);
    end
    tx_valid = 1'b0;
    ena      = 1'b1;
    wait_idle("rand_drain_timeout", 400);

    // default CLKS_PER_BIT instance: 0xA5, start bit then bit0 (=1)
    d_data = 8'hA5; d_valid = 1'b1;
    n = 0;
    while (!d_ready && n < 50) begin step(1); n++; end
    step(1);
    d_valid = 1'b0;
    n = 0;
    while (d_serial !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("def_fall_timeout", n < 20, 1);
    t0 = $time;
    n = 0;
    while (d_serial !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    t1 = $time;
    n = 0;
    while (d_serial !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
    t2 = $time;
    chk("def_start_bit_ns", 32'(t1 - t0), 32'd104160);
    chk("def_bit0_ns", 32'(t2 - t1), 32'd104160);
    d_rst_n = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
